axi_4_lite_master: RTL and testbench
====================================

# axi_4_lite_master

AXI4-Lite master (initiator) that turns single-beat user read/write commands into AXI4-Lite channel traffic toward a register-bank slave. It sits between local control logic and the slave-side register block. It uses the same channel signal names as that slave, with the directions reversed. It has one outstanding transaction at a time, and it returns each completion on a response port held under backpressure.

## Interface
- addr_width, 4, AXI and command address width
- data_width, 32, data width; must be a multiple of 8
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  addr_width  target address
- cmd_wdata  in  data_width  write data (ignored for reads)
- cmd_wstrb  in  data_width/8  byte strobes (ignored for reads)
- awaddr  out  addr_width  write address
- awaddr_valid  out  1  write address valid
- awready  in  1  slave accepts write address
- wdata  out  data_width  write data
- wstrb  out  data_width/8  write strobes
- wdata_valid  out  1  write data valid
- wready  in  1  slave accepts write data
- bdata  in  2  write response code
- bvalid  in  1  write response valid
- bready  out  1  master accepts write response
- araddr  out  addr_width  read address
- araddr_valid  out  1  read address valid
- arready  in  1  slave accepts read address
- rdata  in  data_width  read data
- rresp  in  2  read response code
- rvalid  in  1  read data valid
- rready  out  1  master accepts read data
- rsp_valid  out  1  completion available
- rsp_ready  in  1  user consumes completion
- rsp_write  out  1  completion is for a write
- rsp_rdata  out  data_width  read data; 0 for writes
- rsp_resp  out  2  bdata or rresp, forwarded unmodified

## Operation
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP. Reset forces IDLE.
- cmd_ready = (state==IDLE). It is the only non-registered output. All other outputs are registered.
- IDLE, on accept, latches addr/wdata/wstrb onto the AXI outputs.
  - Write: go to WR with awaddr_valid=1 and wdata_valid=1.
  - Read: go to RD_ADDR with araddr_valid=1.
- WR tracks the AW and W handshakes independently, with done flags.
  - A valid drops on the edge that samples its handshake (valid&&ready).
  - The two handshakes may complete in either order or in the same cycle.
  - When both are done (including same-cycle), go to WR_RESP with bready=1.
- WR_RESP: on bvalid&&bready, capture bdata into rsp_resp. Set rsp_write=1, rsp_rdata=0, bready=0, rsp_valid=1, and go to RSP.
- RD_ADDR: on araddr_valid&&arready, drop araddr_valid, set rready=1, and go to RD_DATA.
- RD_DATA: on rvalid&&rready, capture rdata into rsp_rdata and rresp into rsp_resp. Set rsp_write=0, rready=0, rsp_valid=1, and go to RSP.
- RSP: hold rsp_* stable until rsp_valid&&rsp_ready. On that edge, clear rsp_valid and go to IDLE.
- A valid, once raised, stays high with stable payload until its handshake completes. There is no timeout and no abort.
- Non-OKAY codes (2'b10, 2'b11) are forwarded as-is. They do not change state flow.

## Timing
- Reset values:
  - awaddr_valid, wdata_valid, araddr_valid, bready, rready, rsp_valid, rsp_write = 0.
  - awaddr, wdata, wstrb, araddr, rsp_rdata, rsp_resp = 0.
  - cmd_ready is 1 from the first cycle after reset deasserts.
- Minimum latency, with the slave's ready/valid already high: command accepted at edge 0 → AXI valid high in cycle 1 → address/data handshake at edge 1 → bready/rready high in cycle 2 → response handshake at edge 2 → rsp_valid high in cycle 3.
- Throughput: back-to-back commands have at least one cycle with cmd_ready=1 between rsp_valid&&rsp_ready and the next accept. That gives a minimum 4-cycle period.
- Reset mid-transaction, on the reset edge:
  - All valids, readies and rsp_valid drop.
  - The in-flight command is lost and no completion is issued.
  - The slave must be reset together with the master.
- cmd_valid outside IDLE is ignored (cmd_ready=0). Its inputs may change freely.
- bvalid or rvalid arriving before bready or rready is not consumed. It is consumed in the first cycle the ready is high.

## Test plan
- Write 0xDEADBEEF to addr 0x4 with wstrb 0xF, then read addr 0x4. Required: rsp_write=1, rsp_resp=0 on the write; rsp_rdata=0xDEADBEEF, rsp_resp=0 on the read; each completion in cycle 3 against a zero-wait slave.
- Write 0x11223344 with wstrb 0x5 over a previous 0xAABBCCDD. Read back 0xAA22CC44.
- Slave raises wready 3 cycles before awready. Required: wdata_valid drops right after its handshake; awaddr_valid stays high; bready rises only after the AW handshake.
- Slave delays bvalid 6 cycles, then returns bdata=2'b10. Required: bready stays 1 throughout; rsp_resp=2'b10.
- Hold rsp_ready=0 for 5 cycles after a read completes. Required: rsp_valid and rsp_rdata stay stable; cmd_ready=0 until the consuming edge.
- Assert reset in the WR state with awaddr_valid=1. Required: all valids are 0 the next cycle; no rsp_valid; a new write after reset completes normally.

Source files
------------

// File: rtl/axi_4_lite_master.sv
// ============================================================================
// Module   : axi_4_lite_master
// Brief    : Single-outstanding AXI4-Lite initiator with a held completion port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_4_lite_master #(
   parameter int addr_width = 4,
   parameter int data_width = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [addr_width-1:0]   cmd_addr,
   input  logic [data_width-1:0]   cmd_wdata,
   input  logic [data_width/8-1:0] cmd_wstrb,
   output logic [addr_width-1:0]   awaddr,
   output logic                    awaddr_valid,
   input  logic                    awready,
   output logic [data_width-1:0]   wdata,
   output logic [data_width/8-1:0] wstrb,
   output logic                    wdata_valid,
   input  logic                    wready,
   input  logic [1:0]              bdata,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [addr_width-1:0]   araddr,
   output logic                    araddr_valid,
   input  logic                    arready,
   input  logic [data_width-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [data_width-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp
);

   localparam int c_strb_w = data_width / 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_DATA = 3'd4,
      S_RSP     = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_aw_done, w_aw_done_nxt;
   logic                  r_w_done, w_w_done_nxt;
   logic [addr_width-1:0] w_awaddr_nxt, w_araddr_nxt;
   logic [data_width-1:0] w_wdata_nxt, w_rsp_rdata_nxt;
   logic [c_strb_w-1:0]   w_wstrb_nxt;
   logic                  w_awaddr_valid_nxt, w_wdata_valid_nxt, w_araddr_valid_nxt;
   logic                  w_bready_nxt, w_rready_nxt, w_rsp_valid_nxt, w_rsp_write_nxt;
   logic [1:0]            w_rsp_resp_nxt;
   logic                  w_aw_hs, w_w_hs;

   assign cmd_ready = (r_state == S_IDLE);
   assign w_aw_hs   = awaddr_valid && awready;
   assign w_w_hs    = wdata_valid && wready;

   always_comb begin
      w_state_nxt        = r_state;
      w_aw_done_nxt      = r_aw_done;
      w_w_done_nxt       = r_w_done;
      w_awaddr_nxt       = awaddr;
      w_araddr_nxt       = araddr;
      w_wdata_nxt        = wdata;
      w_wstrb_nxt        = wstrb;
      w_awaddr_valid_nxt = awaddr_valid;
      w_wdata_valid_nxt  = wdata_valid;
      w_araddr_valid_nxt = araddr_valid;
      w_bready_nxt       = bready;
      w_rready_nxt       = rready;
      w_rsp_valid_nxt    = rsp_valid;
      w_rsp_write_nxt    = rsp_write;
      w_rsp_rdata_nxt    = rsp_rdata;
      w_rsp_resp_nxt     = rsp_resp;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_write) begin
                  w_awaddr_nxt       = cmd_addr;
                  w_wdata_nxt        = cmd_wdata;
                  w_wstrb_nxt        = cmd_wstrb;
                  w_awaddr_valid_nxt = 1'b1;
                  w_wdata_valid_nxt  = 1'b1;
                  w_aw_done_nxt      = 1'b0;
                  w_w_done_nxt       = 1'b0;
                  w_state_nxt        = S_WR;
               end else begin
                  w_araddr_nxt       = cmd_addr;
                  w_araddr_valid_nxt = 1'b1;
                  w_state_nxt        = S_RD_ADDR;
               end
            end
         end
         S_WR: begin
            // AW and W complete independently; either order or the same edge
            if (w_aw_hs) begin
               w_awaddr_valid_nxt = 1'b0;
               w_aw_done_nxt      = 1'b1;
            end
            if (w_w_hs) begin
               w_wdata_valid_nxt = 1'b0;
               w_w_done_nxt      = 1'b1;
            end
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
               w_bready_nxt = 1'b1;
               w_state_nxt  = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (bvalid && bready) begin
               w_rsp_resp_nxt  = bdata;
               w_rsp_write_nxt = 1'b1;
               w_rsp_rdata_nxt = '0;
               w_bready_nxt    = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = S_RSP;
            end
         end
         S_RD_ADDR: begin
            if (araddr_valid && arready) begin
               w_araddr_valid_nxt = 1'b0;
               w_rready_nxt       = 1'b1;
               w_state_nxt        = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (rvalid && rready) begin
               w_rsp_rdata_nxt = rdata;
               w_rsp_resp_nxt  = rresp;
               w_rsp_write_nxt = 1'b0;
               w_rready_nxt    = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_valid && rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
         awaddr       <= '0;
         araddr       <= '0;
         wdata        <= '0;
         wstrb        <= '0;
         awaddr_valid <= 1'b0;
         wdata_valid  <= 1'b0;
         araddr_valid <= 1'b0;
         bready       <= 1'b0;
         rready       <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_write    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_resp     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_aw_done    <= w_aw_done_nxt;
         r_w_done     <= w_w_done_nxt;
         awaddr       <= w_awaddr_nxt;
         araddr       <= w_araddr_nxt;
         wdata        <= w_wdata_nxt;
         wstrb        <= w_wstrb_nxt;
         awaddr_valid <= w_awaddr_valid_nxt;
         wdata_valid  <= w_wdata_valid_nxt;
         araddr_valid <= w_araddr_valid_nxt;
         bready       <= w_bready_nxt;
         rready       <= w_rready_nxt;
         rsp_valid    <= w_rsp_valid_nxt;
         rsp_write    <= w_rsp_write_nxt;
         rsp_rdata    <= w_rsp_rdata_nxt;
         rsp_resp     <= w_rsp_resp_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_4_lite_master.sv
// ============================================================================
// Module   : tb_axi_4_lite_master
// Brief    : Directed bench for axi_4_lite_master with a small register-bank slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_4_lite_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [3:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic [3:0]  awaddr, araddr;
   logic        awaddr_valid, awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wdata_valid, wready = 1'b0;
   logic [1:0]  bdata = '0;
   logic        bvalid = 1'b0, bready;
   logic        araddr_valid, arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rvalid = 1'b0, rready;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   int          n_asserts = 0;
   int          n_fail = 0;
   logic [31:0] mem [16];

   axi_4_lite_master #(.addr_width(4), .data_width(32)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .awaddr(awaddr), .awaddr_valid(awaddr_valid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wdata_valid(wdata_valid), .wready(wready),
      .bdata(bdata), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .araddr_valid(araddr_valid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Consume a pending completion after holding rsp_ready low for 'hold' cycles
   task automatic take_rsp(input int hold, input logic exp_write,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
      chk("rsp_write", {31'd0, rsp_write}, {31'd0, exp_write});
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, exp_resp});
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         step();
         chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
         chk("hold_rsp_resp", {30'd0, rsp_resp}, {30'd0, exp_resp});
         chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      chk("rsp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_valid_cleared", {31'd0, rsp_valid}, 32'd0);
      chk("cmd_ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_wait, input int w_wait, input int b_wait,
                            input logic [1:0] code, input int exp_cyc, input bit junk);
      int cyc = 1;
      int bfirst = -1;
      bit aw_seen = 0, w_seen = 0, b_seen = 0;
      bit aw_hs, w_hs, b_hs;
      chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      step();
      cmd_valid = 1'b0;
      while (!rsp_valid && cyc <= 40) begin
         if (junk) begin
            cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 4'($urandom);
            cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
         end
         chk("wr_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
         chk("awaddr_valid", {31'd0, awaddr_valid}, {31'd0, !aw_seen});
         chk("wdata_valid", {31'd0, wdata_valid}, {31'd0, !w_seen});
         chk("bready", {31'd0, bready}, {31'd0, aw_seen && w_seen && !b_seen});
         awready = !aw_seen && (cyc >= 1 + aw_wait);
         wready  = !w_seen && (cyc >= 1 + w_wait);
         if (bready && bfirst < 0) bfirst = cyc;
         bvalid = (bfirst >= 0) && (cyc >= bfirst + b_wait) && !b_seen;
         bdata  = code;
         aw_hs = awaddr_valid && awready;
         w_hs  = wdata_valid && wready;
         b_hs  = bvalid && bready;
         if (aw_hs) chk("awaddr", {28'd0, awaddr}, {28'd0, addr});
         if (w_hs) begin
            chk("wdata", wdata, data);
            chk("wstrb", {28'd0, wstrb}, {28'd0, strb});
            for (int b = 0; b < 4; b++)
               if (wstrb[b]) mem[addr][8*b +: 8] = wdata[8*b +: 8];
         end
         step();
         aw_seen |= aw_hs; w_seen |= w_hs; b_seen |= b_hs;
         cyc++;
      end
      cmd_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("wr_latency", cyc, exp_cyc);
   endtask

   task automatic axi_read(input logic [3:0] addr, input int ar_wait, input int r_wait,
                           input logic [1:0] code, input int exp_cyc);
      int cyc = 1;
      int rfirst = -1;
      bit ar_seen = 0, r_seen = 0;
      bit ar_hs, r_hs;
      chk("rd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_wdata = 32'h5A5A5A5A;
      step();
      cmd_valid = 1'b0;
      while (!rsp_valid && cyc <= 40) begin
         chk("rd_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
         chk("araddr_valid", {31'd0, araddr_valid}, {31'd0, !ar_seen});
         chk("rready", {31'd0, rready}, {31'd0, ar_seen && !r_seen});
         chk("rd_awaddr_valid", {31'd0, awaddr_valid}, 32'd0);
         arready = !ar_seen && (cyc >= 1 + ar_wait);
         if (rready && rfirst < 0) rfirst = cyc;
         rvalid = (rfirst >= 0) && (cyc >= rfirst + r_wait) && !r_seen;
         rdata  = mem[addr];
         rresp  = code;
         ar_hs = araddr_valid && arready;
         r_hs  = rvalid && rready;
         if (ar_hs) chk("araddr", {28'd0, araddr}, {28'd0, addr});
         step();
         ar_seen |= ar_hs; r_seen |= r_hs;
         cyc++;
      end
      arready = 1'b0; rvalid = 1'b0; rdata = 32'hBAD0BAD0;
      chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rd_latency", cyc, exp_cyc);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      reset = 1'b1;
      step(); step(); step();
      reset = 1'b0;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_valids", {26'd0, awaddr_valid, wdata_valid, araddr_valid, bready, rready, rsp_valid}, 32'd0);
      chk("rst_rsp_write", {31'd0, rsp_write}, 32'd0);
      chk("rst_addrs", {24'd0, awaddr, araddr}, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_resp", {30'd0, rsp_resp}, 32'd0);

      // zero-wait write then read-back
      axi_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 3, 1'b0);
      take_rsp(0, 1'b1, 32'h0, 2'b00);
      axi_read(4'h4, 0, 0, 2'b00, 3);
      take_rsp(0, 1'b0, 32'hDEADBEEF, 2'b00);

      // partial-strobe overwrite
      axi_write(4'h8, 32'hAABBCCDD, 4'hF, 0, 0, 0, 2'b00, 3, 1'b0);
      take_rsp(0, 1'b1, 32'h0, 2'b00);
      axi_write(4'h8, 32'h11223344, 4'h5, 0, 0, 0, 2'b00, 3, 1'b0);
      take_rsp(0, 1'b1, 32'h0, 2'b00);
      axi_read(4'h8, 0, 0, 2'b00, 3);
      take_rsp(0, 1'b0, 32'hAA22CC44, 2'b00);

      // W completes three cycles ahead of AW
      axi_write(4'hC, 32'h01020304, 4'hF, 3, 0, 0, 2'b00, 6, 1'b0);
      take_rsp(0, 1'b1, 32'h0, 2'b00);

      // late SLVERR write response while junk commands are offered
      axi_write(4'h0, 32'hFFFF0000, 4'h3, 0, 0, 6, 2'b10, 9, 1'b1);
      take_rsp(0, 1'b1, 32'h0, 2'b10);

      // slow read with DECERR, completion held for 5 cycles
      axi_read(4'hC, 2, 1, 2'b11, 6);
      take_rsp(5, 1'b0, 32'h01020304, 2'b11);

      // reset while the write address is still pending
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
      step();
      cmd_valid = 1'b0;
      step();
      chk("mid_awaddr_valid", {31'd0, awaddr_valid}, 32'd1);
      chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_valids", {26'd0, awaddr_valid, wdata_valid, araddr_valid, bready, rready, rsp_valid}, 32'd0);
      chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      step();
      chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      axi_write(4'h4, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b00, 3, 1'b0);
      take_rsp(0, 1'b1, 32'h0, 2'b00);
      axi_read(4'h4, 0, 0, 2'b00, 3);
      take_rsp(0, 1'b0, 32'hCAFEF00D, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
